// File: rtl/v_pkg.sv
// Shared types for the level-0 notify path: product id, key, size and the
// queued notification record.
package v_pkg;

  typedef logic [7:0]  id_t;
  typedef logic [31:0] key_t;
  typedef logic [15:0] size_t;

  localparam int NOTIFY_DEPTH = 8;

  typedef struct packed {
    id_t   prod_id;
    key_t  key;
    size_t size;
  } notify_t;

endpackage

// File: rtl/v_notify_queue_cam.sv
// Combinational product-id match against every queue entry, masked by the
// entry valid bits. The queue keeps at most one valid entry per id.
module v_notify_queue_cam
  import v_pkg::*;
#(
  parameter int DEPTH = NOTIFY_DEPTH
) (
  input  id_t               id_i,
  input  id_t [DEPTH-1:0]   ent_id_i,
  input  logic [DEPTH-1:0]  vld_i,
  output logic [DEPTH-1:0]  match_o,
  output logic              hit_o
);

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign match_o[g] = vld_i[g] & (ent_id_i[g] == id_i);
  end

  assign hit_o = |match_o;

endmodule

// File: rtl/v_notify_queue.sv
// Coalescing circular notify queue between the level-0 update bus and the
// egress publisher. Pending ids are updated in place; overflow drops count.
module v_notify_queue
  import v_pkg::*;
#(
  parameter int DEPTH = NOTIFY_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_lv0_vld,
  input  id_t              i_lv0_prod_id,
  input  key_t             i_lv0_key,
  input  size_t            i_lv0_size,
  output logic             o_ntf_vld_r,
  output id_t              o_ntf_prod_id_r,
  output key_t             o_ntf_key_r,
  output size_t            o_ntf_size_r,
  input  logic             i_ntf_rdy,
  input  logic             i_clr,
  output logic             o_ovfl_r,
  output logic [CNT_W-1:0] o_drop_cnt_r,
  output logic             o_full_r,
  output logic             o_empty_r
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  notify_t [DEPTH-1:0] ent_q;
  id_t     [DEPTH-1:0] ent_id;
  logic    [DEPTH-1:0] vld_q, vld_d;
  logic    [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic    [CW-1:0]    cnt_q, cnt_d;
  logic                ntf_vld_q, full_q, empty_q, ovfl_q;
  logic    [CNT_W-1:0] drop_q;

  logic [DEPTH-1:0] match, head_oh, hit_eff;
  logic             hit_any, pop, coal, alloc, drop, at_cap;

  for (genvar g = 0; g < DEPTH; g++) begin : g_id
    assign ent_id[g] = ent_q[g].prod_id;
  end

  v_notify_queue_cam #(.DEPTH(DEPTH)) u_cam (
    .id_i     (i_lv0_prod_id),
    .ent_id_i (ent_id),
    .vld_i    (vld_q),
    .match_o  (match),
    .hit_o    (hit_any)
  );

  // A match on the head that is leaving this cycle must not absorb the new
  // notification, otherwise the update would be lost with the popped entry.
  assign pop     = ntf_vld_q & i_ntf_rdy;
  assign head_oh = {{(DEPTH-1){1'b0}}, 1'b1} << rd_ptr_q;
  assign hit_eff = match & ~(pop ? head_oh : '0);
  assign at_cap  = (cnt_q == CW'(DEPTH));
  assign coal    = i_lv0_vld & hit_any & (|hit_eff);
  assign alloc   = i_lv0_vld & ~coal & (~at_cap | pop);
  assign drop    = i_lv0_vld & ~coal & ~alloc;

  always_comb begin
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(alloc);
    cnt_d    = cnt_q + CW'(alloc) - CW'(pop);
    if (pop)   vld_d[rd_ptr_q] = 1'b0;
    // Set after clear: when full, alloc and pop share the same slot.
    if (alloc) vld_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      ntf_vld_q <= 1'b0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      vld_q     <= vld_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      ntf_vld_q <= (cnt_d != '0);
      full_q    <= (cnt_d == CW'(DEPTH));
      empty_q   <= (cnt_d == '0);
    end
  end

  // Entry payload carries no reset; validity is tracked by vld_q alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc && (wr_ptr_q == PW'(i))) begin
        ent_q[i] <= '{prod_id: i_lv0_prod_id, key: i_lv0_key, size: i_lv0_size};
      end else if (coal && hit_eff[i]) begin
        ent_q[i].key  <= i_lv0_key;
        ent_q[i].size <= i_lv0_size;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovfl_q <= 1'b0;
      drop_q <= '0;
    end else if (i_clr) begin
      ovfl_q <= 1'b0;
      drop_q <= '0;
    end else if (drop) begin
      ovfl_q <= 1'b1;
      if (drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end

  assign o_ntf_vld_r     = ntf_vld_q;
  assign o_ntf_prod_id_r = ent_q[rd_ptr_q].prod_id;
  assign o_ntf_key_r     = ent_q[rd_ptr_q].key;
  assign o_ntf_size_r    = ent_q[rd_ptr_q].size;
  assign o_ovfl_r        = ovfl_q;
  assign o_drop_cnt_r    = drop_q;
  assign o_full_r        = full_q;
  assign o_empty_r       = empty_q;

endmodule

// File: tb/tb_v_notify_queue.sv
// Scoreboard bench for v_notify_queue: expected egress order is queued as
// stimulus is driven and compared against notifications actually popped.
module tb_v_notify_queue;
  import v_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  lv0_vld = 1'b0;
  id_t   lv0_id = '0;
  key_t  lv0_key = '0;
  size_t lv0_size = '0;
  logic  rdy = 1'b0;
  logic  clr = 1'b0;

  logic        o_vld, o_ovfl, o_full, o_empty;
  id_t         o_id;
  key_t        o_key;
  size_t       o_size;
  logic [15:0] o_drop;

  logic        s_vld, s_ovfl, s_full, s_empty;
  id_t         s_id;
  key_t        s_key;
  size_t       s_size;
  logic [1:0]  s_drop;

  int checks = 0;
  int failures = 0;

  notify_t exp_q[$];
  notify_t obs_q[$];

  always #5 clk = ~clk;

  v_notify_queue #(.DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_lv0_vld(lv0_vld), .i_lv0_prod_id(lv0_id),
    .i_lv0_key(lv0_key), .i_lv0_size(lv0_size), .o_ntf_vld_r(o_vld),
    .o_ntf_prod_id_r(o_id), .o_ntf_key_r(o_key), .o_ntf_size_r(o_size),
    .i_ntf_rdy(rdy), .i_clr(clr), .o_ovfl_r(o_ovfl), .o_drop_cnt_r(o_drop),
    .o_full_r(o_full), .o_empty_r(o_empty)
  );

  v_notify_queue #(.DEPTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .i_lv0_vld(lv0_vld), .i_lv0_prod_id(lv0_id),
    .i_lv0_key(lv0_key), .i_lv0_size(lv0_size), .o_ntf_vld_r(s_vld),
    .o_ntf_prod_id_r(s_id), .o_ntf_key_r(s_key), .o_ntf_size_r(s_size),
    .i_ntf_rdy(rdy), .i_clr(clr), .o_ovfl_r(s_ovfl), .o_drop_cnt_r(s_drop),
    .o_full_r(s_full), .o_empty_r(s_empty)
  );

  // One clock: drive at the falling edge, record a pop seen before the rising
  // edge, and return at the next falling edge with outputs settled.
  task automatic step(input logic v, input id_t id, input key_t k,
                      input size_t s, input logic r, input logic c);
    lv0_vld = v; lv0_id = id; lv0_key = k; lv0_size = s; rdy = r; clr = c;
    #1;
    if (o_vld && r) obs_q.push_back('{prod_id: o_id, key: o_key, size: o_size});
    @(posedge clk);
    @(negedge clk);
    lv0_vld = 1'b0; clr = 1'b0;
  endtask

  task automatic push(input id_t id, input key_t k, input size_t s, input logic r);
    step(1'b1, id, k, s, r, 1'b0);
  endtask

  task automatic idle(input logic r);
    step(1'b0, '0, '0, '0, r, 1'b0);
  endtask

  task automatic test_reset;
    #12;
    checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", o_vld); end
    checks++; if (o_ovfl !== 1'b0) begin failures++; $display("FAIL reset_ovfl got=%b exp=0", o_ovfl); end
    checks++; if (o_drop !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", o_drop); end
    checks++; if (o_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", o_full); end
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", o_empty); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    push(8'd3, 32'd100, 16'd5, 1'b1);
    exp_q.push_back('{prod_id: 8'd3, key: 32'd100, size: 16'd5});
    checks++; if ({o_vld, o_id, o_key, o_size} !== {1'b1, 8'd3, 32'd100, 16'd5}) begin
      failures++; $display("FAIL single_head got=%b/%0d/%0d/%0d exp=1/3/100/5", o_vld, o_id, o_key, o_size); end
    checks++; if (o_empty !== 1'b0) begin failures++; $display("FAIL single_nonempty got=%b exp=0", o_empty); end
    idle(1'b1);
    checks++; if ({o_vld, o_empty} !== 2'b01) begin failures++; $display("FAIL single_empty got=%b exp=01", {o_vld, o_empty}); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL single_out%0d got=%h exp=%h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]); end
    end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL single_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_coalesce;
    push(8'd3, 32'd100, 16'd1, 1'b0);
    push(8'd7, 32'd200, 16'd2, 1'b0);
    push(8'd3, 32'd101, 16'd3, 1'b0);
    exp_q.push_back('{prod_id: 8'd3, key: 32'd101, size: 16'd3});
    exp_q.push_back('{prod_id: 8'd7, key: 32'd200, size: 16'd2});
    checks++; if ({o_id, o_key, o_size} !== {8'd3, 32'd101, 16'd3}) begin
      failures++; $display("FAIL coal_head got=%0d/%0d/%0d exp=3/101/3", o_id, o_key, o_size); end
    idle(1'b1);
    idle(1'b1);
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL coal_empty got=%b exp=1 (count was not 2)", o_empty); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL coal_out%0d got=%h exp=%h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]); end
    end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL coal_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_head_pop;
    push(8'd3, 32'd100, 16'd1, 1'b0);
    exp_q.push_back('{prod_id: 8'd3, key: 32'd100, size: 16'd1});
    push(8'd3, 32'd102, 16'd2, 1'b1);
    exp_q.push_back('{prod_id: 8'd3, key: 32'd102, size: 16'd2});
    checks++; if ({o_vld, o_key, o_empty} !== {1'b1, 32'd102, 1'b0}) begin
      failures++; $display("FAIL hpop_head got=%b/%0d/%b exp=1/102/0", o_vld, o_key, o_empty); end
    idle(1'b1);
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL hpop_empty got=%b exp=1", o_empty); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL hpop_out%0d got=%h exp=%h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]); end
    end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL hpop_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_overflow;
    for (int i = 10; i < 18; i++) begin
      push(id_t'(i), key_t'(1000 + i), size_t'(i), 1'b0);
      exp_q.push_back('{prod_id: id_t'(i), key: key_t'(1000 + i), size: size_t'(i)});
    end
    push(8'd9, 32'd900, 16'd9, 1'b0);
    checks++; if ({o_full, o_ovfl} !== 2'b11) begin failures++; $display("FAIL ovf_flags got=%b exp=11", {o_full, o_ovfl}); end
    checks++; if (o_drop !== 16'd1) begin failures++; $display("FAIL ovf_drop got=%0d exp=1", o_drop); end
    push(8'd9, 32'd901, 16'd9, 1'b1);
    exp_q.push_back('{prod_id: 8'd9, key: 32'd901, size: 16'd9});
    checks++; if (o_full !== 1'b1) begin failures++; $display("FAIL ovf_full_pop got=%b exp=1", o_full); end
    checks++; if (o_drop !== 16'd1) begin failures++; $display("FAIL ovf_drop_pop got=%0d exp=1", o_drop); end
    for (int i = 0; i < 8; i++) idle(1'b1);
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL ovf_drained got=%b exp=1", o_empty); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL ovf_out%0d got=%h exp=%h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]); end
    end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    exp_q.delete(); obs_q.delete();
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    checks++; if ({o_ovfl, o_drop} !== 17'd0) begin failures++; $display("FAIL ovf_clr got=%b/%0d exp=0/0", o_ovfl, o_drop); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 24; i++) begin
      push(id_t'(20 + i), key_t'(3 * i + 1), size_t'(i), 1'b1);
      exp_q.push_back('{prod_id: id_t'(20 + i), key: key_t'(3 * i + 1), size: size_t'(i)});
    end
    idle(1'b1);
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", o_empty); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL wrap_out%0d got=%h exp=%h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]); end
    end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) push(id_t'(40 + i), key_t'(i), size_t'(i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({o_vld, o_empty, o_full} !== 3'b010) begin
      failures++; $display("FAIL rmid_async got=%b exp=010", {o_vld, o_empty, o_full}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b1);
    checks++; if ({o_vld, o_empty} !== 2'b01) begin failures++; $display("FAIL rmid_idle got=%b exp=01", {o_vld, o_empty}); end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rmid_stale got=%0d exp=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 13; i++) push(id_t'(60 + i), key_t'(i), size_t'(i), 1'b0);
    checks++; if (s_drop !== 2'd3) begin failures++; $display("FAIL sat_cnt got=%0d exp=3", s_drop); end
    checks++; if (o_drop !== 16'd5) begin failures++; $display("FAIL sat_wide got=%0d exp=5", o_drop); end
    checks++; if (s_ovfl !== 1'b1) begin failures++; $display("FAIL sat_ovfl got=%b exp=1", s_ovfl); end
    step(1'b1, 8'd99, 32'd7, 16'd7, 1'b0, 1'b1);
    checks++; if ({s_ovfl, s_drop, o_ovfl, o_drop} !== 20'd0) begin
      failures++; $display("FAIL sat_clr got=%b/%0d/%b/%0d exp=0/0/0/0", s_ovfl, s_drop, o_ovfl, o_drop); end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_coalesce();
    test_head_pop();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
